// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational alu: accepts one command, captures the result, returns it.
// Optional feature: define ALU_ISSUE_ZERO_FLAG_EN to add the registered rsp_zero output.

`ifndef WORDSIZE
`define WORDSIZE 8
`endif

module alu_issue_ctrl #(
  parameter int unsigned WIDTH = `WORDSIZE,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_s,
  input  logic [WIDTH-1:0] alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  output logic             rsp_zero,
`endif
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   load_cmd;
  logic   cap_rsp;
  logic   rsp_done;

  // Next-state and datapath load strobes.
  always_comb begin
    state_d  = state_q;
    load_cmd = 1'b0;
    cap_rsp  = 1'b0;
    rsp_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          load_cmd = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        cap_rsp = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Status flags are registered from the next state so they track state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      cmd_ready <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      rsp_valid <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_s <= 2'b00;
    end else if (load_cmd) begin
      alu_a <= cmd_a;
      alu_b <= cmd_b;
      alu_s <= cmd_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_data <= '0;
    else if (cap_rsp) rsp_data <= alu_y;
  end

`ifdef ALU_ISSUE_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_zero <= 1'b0;
    else if (cap_rsp) rsp_zero <= (alu_y == '0);
  end
`endif

  // Completed-response counter, wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count <= '0;
    else if (rsp_done) op_count <= op_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with an alu stub (00 add, 01 sub, 10 and, 11 or).
// Build with ALU_ISSUE_ZERO_FLAG_EN defined to also check rsp_zero.

module tb_alu_issue_ctrl;

  localparam int unsigned W   = 8;
  localparam int unsigned CNT = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [1:0]     cmd_op = 2'b00;
  logic [W-1:0]   cmd_a = '0;
  logic [W-1:0]   cmd_b = '0;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [1:0]     alu_s;
  logic [W-1:0]   alu_y;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [W-1:0]   rsp_data;
  logic           busy;
  logic [CNT-1:0] op_count;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  logic           rsp_zero;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int model_count = 0;

  always #5 clk = ~clk;

  // alu stub
  always_comb begin
    case (alu_s)
      2'b00:   alu_y = alu_a + alu_b;
      2'b01:   alu_y = alu_a - alu_b;
      2'b10:   alu_y = alu_a & alu_b;
      default: alu_y = alu_a | alu_b;
    endcase
  end

  alu_issue_ctrl #(.WIDTH(W), .CNT_W(CNT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy),
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    .rsp_zero(rsp_zero),
`endif
    .op_count(op_count)
  );

  // Reference result computed with integer arithmetic, reduced modulo 2^W.
  function automatic int ref_result(input int op, input int a, input int b);
    int r;
    case (op)
      0:       r = a + b;
      1:       r = a - b + (1 << W);
      2:       r = a & b;
      default: r = a | b;
    endcase
    return r % (1 << W);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input int cnt);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_op_count"}, 32'(op_count), 32'(cnt % (1 << CNT)));
  endtask

  // One full command/response transaction; hold = cycles rsp_ready stays low in DONE.
  task automatic run_op(input int op, input int a, input int b, input int hold);
    int exp;
    int waited;
    exp = ref_result(op, a, b);
    @(negedge clk);
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_a     = W'(a);
    cmd_b     = W'(b);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = (hold == 0);
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_cmd_ready", 32'(cmd_ready), 32'd0);
    check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check("exec_alu_in", {16'd0, 6'd0, alu_s, alu_a}, {16'd0, 6'd0, 2'(op), W'(a)});
    check("exec_alu_b", 32'(alu_b), 32'(b));
    @(posedge clk); #1;
    check("done_rsp_valid", 32'(rsp_valid), 32'd1);
    check("done_rsp_data", 32'(rsp_data), 32'(exp));
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    check("done_rsp_zero", 32'(rsp_zero), 32'(exp == 0));
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_data", 32'(rsp_data), 32'(exp));
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    model_count++;
    check_idle_outputs("after_rsp", model_count);
    check("after_rsp_data_kept", 32'(rsp_data), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_count = 0;
    check_idle_outputs("rst", 0);
    check("rst_alu", {alu_s, alu_a, alu_b}, 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int a_tab [4];
    int b_tab [4];
    a_tab = '{1, 1, 0, 0};
    b_tab = '{1, 0, 1, 0};

    // 1. Reset asserted mid-cycle
    #17 rst_n = 1'b1;
    run_op(3, 8'h5a, 8'h0f, 0);
    do_reset();

    // 2. Single op
    run_op(0, 1, 1, 0);

    // 3. Backpressure for five cycles
    run_op(1, 1, 0, 5);

    // rsp_ready while idle has no effect
    @(negedge clk);
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rsp_ready = 1'b0;
    check_idle_outputs("idle_rsp_ready", model_count);

    // 4. Sweep all ops over the operand table
    do_reset();
    for (int op = 0; op < 4; op++)
      for (int k = 0; k < 4; k++)
        run_op(op, a_tab[k], b_tab[k], 0);
    check("sweep_count", 32'(op_count), 32'(16 % (1 << CNT)));

    // 5. Reset while in EXEC
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'd7; cmd_b = 8'd9;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    check("midop_exec_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    model_count = 0;
    check_idle_outputs("midop_rst", 0);
    check("midop_rsp_data", 32'(rsp_data), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midop_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b0;
    run_op(2, 8'hf0, 8'h3c, 1);

    // 6. Counter wrap with a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++)
      run_op(2, 1, 0, 0);
    check("wrap_count", 32'(op_count), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 40; i++)
      run_op(int'($urandom_range(3)), int'($urandom_range(255)),
             int'($urandom_range(255)), int'($urandom_range(3)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
